// File: rtl/cdc_handshake_arbiter.sv
`timescale 1ns/1ps
// Purpose: shares one clk_src->clk_dst crossing among NUM_REQ requesters (round-robin, 4-phase req/ack).
// Latency: dst_valid rises SYNC_STAGES+1 clk_dst edges after the clk_src grant edge (+1 for phase).
// Backpressure: dst_ready low holds the word in VALID; src_ready stays 0 until the handshake closes.

// Reset synchronizer: asserts asynchronously, releases after two clock edges.
module cdc_handshake_arbiter_rst_sync (
    input  logic clk,
    input  logic arst_n,
    output logic rst_n
);
    logic [1:0] sync_q;

    // Shift ones in after async_reset releases; clear immediately on assertion.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n = sync_q[1];
endmodule

// Single-bit level synchronizer of STAGES flops into the clk domain.
module cdc_handshake_arbiter_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;

    // Plain shift chain; only the last flop is consumed by logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// Top: round-robin arbiter + held word in clk_src, 4-phase handshake to a clk_dst output register.
module cdc_handshake_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_src,
    input  logic                         async_reset,
    input  logic                         clk_dst,
    input  logic [NUM_REQ-1:0]           src_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    src_data,
    output logic [NUM_REQ-1:0]           src_ready,
    output logic                         busy,
    output logic                         dst_valid,
    output logic [DATA_W-1:0]            dst_data,
    output logic [$clog2(NUM_REQ)-1:0]   dst_id,
    input  logic                         dst_ready
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } src_state_t;

    typedef enum logic [1:0] {
        D_WAIT  = 2'd0,
        D_VALID = 2'd1,
        D_ACK   = 2'd2
    } dst_state_t;

    // ------------------------------------------------------------------
    // Per-domain reset release
    // ------------------------------------------------------------------
    logic rst_src_n;
    logic rst_dst_n;

    cdc_handshake_arbiter_rst_sync u_rst_src (
        .clk    (clk_src),
        .arst_n (async_reset),
        .rst_n  (rst_src_n)
    );

    cdc_handshake_arbiter_rst_sync u_rst_dst (
        .clk    (clk_dst),
        .arst_n (async_reset),
        .rst_n  (rst_dst_n)
    );

    // ------------------------------------------------------------------
    // Source domain state
    // ------------------------------------------------------------------
    src_state_t         src_state_q, src_state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic [ID_W-1:0]    hold_id_q, hold_id_d;
    logic               req_q, req_d;
    logic               ack_sync;

    // ------------------------------------------------------------------
    // Destination domain state
    // ------------------------------------------------------------------
    dst_state_t         dst_state_q, dst_state_d;
    logic               dst_valid_q, dst_valid_d;
    logic [DATA_W-1:0]  dst_data_q, dst_data_d;
    logic [ID_W-1:0]    dst_id_q, dst_id_d;
    logic               ack_q, ack_d;
    logic               req_sync;

    cdc_handshake_arbiter_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_src),
        .rst_n (rst_src_n),
        .d     (ack_q),
        .q     (ack_sync)
    );

    cdc_handshake_arbiter_bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk_dst),
        .rst_n (rst_dst_n),
        .d     (req_q),
        .q     (req_sync)
    );

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  src_word [NUM_REQ];
    logic [ID_W-1:0]    arb_win;
    logic [ID_W-1:0]    cand_id;
    logic               arb_any;
    logic               grant_vld;
    int                 cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign src_word[gi] = src_data[gi*DATA_W +: DATA_W];
    end

    // Search from last_grant+1 with wrap; first valid requester wins.
    always_comb begin
        arb_win = last_grant_q;
        arb_any = 1'b0;
        cand    = 0;
        cand_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_id = ID_W'(cand);
            if (!arb_any && src_valid[cand_id]) begin
                arb_any = 1'b1;
                arb_win = cand_id;
            end
        end
    end

    // Grants only issue from IDLE and never while the source domain is held in reset.
    assign grant_vld = rst_src_n && (src_state_q == S_IDLE) && arb_any;

    // One-hot ready towards the winning requester.
    always_comb begin
        src_ready = '0;
        if (grant_vld) begin
            src_ready[arb_win] = 1'b1;
        end
    end

    assign busy = (src_state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Source FSM: IDLE -> REQ -> DROP -> IDLE
    // ------------------------------------------------------------------

    // Source state registers; hold word stays frozen from grant until back in IDLE.
    always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) begin
            src_state_q  <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            hold_data_q  <= '0;
            hold_id_q    <= '0;
            req_q        <= 1'b0;
        end else begin
            src_state_q  <= src_state_d;
            last_grant_q <= last_grant_d;
            hold_data_q  <= hold_data_d;
            hold_id_q    <= hold_id_d;
            req_q        <= req_d;
        end
    end

    // Source next-state: capture on grant, raise req, then follow the ack level.
    always_comb begin
        src_state_d  = src_state_q;
        last_grant_d = last_grant_q;
        hold_data_d  = hold_data_q;
        hold_id_d    = hold_id_q;
        req_d        = req_q;
        unique case (src_state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    hold_data_d  = src_word[arb_win];
                    hold_id_d    = arb_win;
                    last_grant_d = arb_win;
                    req_d        = 1'b1;
                    src_state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_sync) begin
                    req_d       = 1'b0;
                    src_state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (!ack_sync) begin
                    src_state_d = S_IDLE;
                end
            end
            default: begin
                req_d       = 1'b0;
                src_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Destination FSM: WAIT -> VALID -> ACK -> WAIT
    // ------------------------------------------------------------------

    // Destination state registers.
    always_ff @(posedge clk_dst or negedge rst_dst_n) begin
        if (!rst_dst_n) begin
            dst_state_q <= D_WAIT;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_id_q    <= '0;
            ack_q       <= 1'b0;
        end else begin
            dst_state_q <= dst_state_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            dst_id_q    <= dst_id_d;
            ack_q       <= ack_d;
        end
    end

    // Destination next-state: hold_* are quasi-static while req is high, so they are sampled directly.
    always_comb begin
        dst_state_d = dst_state_q;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        dst_id_d    = dst_id_q;
        ack_d       = ack_q;
        unique case (dst_state_q)
            D_WAIT: begin
                if (req_sync) begin
                    dst_data_d  = hold_data_q;
                    dst_id_d    = hold_id_q;
                    dst_valid_d = 1'b1;
                    dst_state_d = D_VALID;
                end
            end
            D_VALID: begin
                if (dst_ready) begin
                    dst_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    dst_state_d = D_ACK;
                end
            end
            D_ACK: begin
                if (!req_sync) begin
                    ack_d       = 1'b0;
                    dst_state_d = D_WAIT;
                end
            end
            default: begin
                dst_valid_d = 1'b0;
                ack_d       = 1'b0;
                dst_state_d = D_WAIT;
            end
        endcase
    end

    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;
    assign dst_id    = dst_id_q;

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
`timescale 1ns/1ps
// Purpose: directed and randomised checks of cdc_handshake_arbiter across two clock ratios.
// Latency: per-word handshake observed through src and dst side logs.
// Backpressure: dst_ready driven constant, held low, or random per clk_dst cycle.
module tb_cdc_handshake_arbiter;

    logic         clk_src = 1'b0;
    logic         clk_dst = 1'b0;
    logic         async_reset = 1'b0;
    logic [3:0]   src_valid = '0;
    logic [31:0]  src_data = '0;
    logic [3:0]   src_ready;
    logic         busy;
    logic         dst_valid;
    logic [7:0]   dst_data;
    logic [1:0]   dst_id;
    logic         dst_ready = 1'b0;

    realtime      src_half = 5.0;
    realtime      dst_half = 13.5;

    int           n_checks = 0;
    int           n_errors = 0;

    logic [7:0]   pend [4][$];
    int           rd_ptr [4] = '{default: 0};
    logic [3:0]   gnt_now = '0;
    logic [15:0]  gq [$];
    logic [15:0]  rx_q [$];
    logic         rdy_en = 1'b0;
    logic         rdy_rand = 1'b0;

    cdc_handshake_arbiter #(
        .NUM_REQ     (4),
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_src     (clk_src),
        .async_reset (async_reset),
        .clk_dst     (clk_dst),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .busy        (busy),
        .dst_valid   (dst_valid),
        .dst_data    (dst_data),
        .dst_id      (dst_id),
        .dst_ready   (dst_ready)
    );

    initial forever #(src_half) clk_src = ~clk_src;
    initial forever #(dst_half) clk_dst = ~clk_dst;

    // Producers: each requester presents the head of its queue until granted.
    always @(posedge clk_src) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (!async_reset) rd_ptr[i] = pend[i].size();
            else if (gnt_now[i]) rd_ptr[i] = rd_ptr[i] + 1;
            if (rd_ptr[i] < pend[i].size()) begin
                src_valid[i]       = 1'b1;
                src_data[i*8 +: 8] = pend[i][rd_ptr[i]];
            end else begin
                src_valid[i]       = 1'b0;
                src_data[i*8 +: 8] = 8'h00;
            end
        end
    end

    // Grant log, sampled mid-cycle.
    always @(negedge clk_src) begin
        gnt_now = src_valid & src_ready;
        for (int i = 0; i < 4; i++) begin
            if (gnt_now[i]) gq.push_back({6'd0, 2'(i), src_data[i*8 +: 8]});
        end
    end

    // Consumer ready driver.
    always @(posedge clk_dst) begin
        #1;
        dst_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_en;
    end

    // Receive log, sampled mid-cycle.
    always @(negedge clk_dst) begin
        if (dst_valid && dst_ready) rx_q.push_back({6'd0, dst_id, dst_data});
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: run did not complete (checks=%0d errors=%0d)", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] w(input int id, input logic [7:0] d);
        return {6'd0, 2'(id), d};
    endfunction

    function automatic logic [15:0] rx_at(input int k);
        return (k < rx_q.size()) ? rx_q[k] : 16'hFFFF;
    endfunction

    function automatic logic [15:0] gq_at(input int k);
        return (k < gq.size()) ? gq[k] : 16'hFFFF;
    endfunction

    task automatic src_sync();
        @(negedge clk_src);
        #1;
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int c = 0; c < budget && rx_q.size() < target; c++) @(negedge clk_dst);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk_dst);
        repeat (3) @(posedge clk_src);
        async_reset = 1'b1;
        repeat (4) @(posedge clk_src);
        repeat (4) @(posedge clk_dst);
        src_sync();
    endtask

    task automatic do_reset(input string tag);
        src_sync();
        async_reset = 1'b0;
        #2;
        check({tag, "_src_ready"}, 32'(src_ready), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_dst_valid"}, 32'(dst_valid), 0);
        check({tag, "_dst_data"},  32'(dst_data), 0);
        check({tag, "_dst_id"},    32'(dst_id), 0);
        release_reset();
    endtask

    task automatic run_random(input string tag, input int nwords);
        int pb [4];
        int ptr [4];
        int rb;
        int gb;
        int bad;
        int left;
        logic [15:0] e;
        do_reset(tag);
        rdy_rand = 1'b1;
        rb = rx_q.size();
        gb = gq.size();
        for (int i = 0; i < 4; i++) pb[i] = pend[i].size();
        for (int k = 0; k < nwords; k++) pend[$urandom_range(0, 3)].push_back(8'($urandom));
        wait_rx(rb + nwords, 40000);
        repeat (50) @(negedge clk_dst);
        rdy_rand = 1'b0;
        check({tag, "_count"}, 32'(rx_q.size() - rb), 32'(nwords));
        bad = 0;
        for (int k = rb; k < rx_q.size(); k++) begin
            if (rx_q[k] !== gq_at(gb + k - rb)) bad++;
        end
        check({tag, "_grant_vs_rx"}, 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < 4; i++) ptr[i] = pb[i];
        for (int k = rb; k < rx_q.size(); k++) begin
            e = rx_q[k];
            if (ptr[e[9:8]] < pend[e[9:8]].size() && pend[e[9:8]][ptr[e[9:8]]] === e[7:0]) begin
                ptr[e[9:8]]++;
            end else begin
                bad++;
                ptr[e[9:8]]++;
            end
        end
        check({tag, "_per_req_order"}, 32'(bad), 0);
        left = 0;
        for (int i = 0; i < 4; i++) left += pend[i].size() - ptr[i];
        check({tag, "_unserved"}, 32'(left), 0);
    endtask

    initial begin
        int b_rx;
        int b_g;

        do_reset("rst0");

        // Single requester 0, 0xA5.
        rdy_en = 1'b1;
        b_rx = rx_q.size();
        b_g  = gq.size();
        pend[0].push_back(8'hA5);
        wait_rx(b_rx + 1, 200);
        repeat (40) @(negedge clk_dst);
        check("t1_rx_count", 32'(rx_q.size() - b_rx), 1);
        check("t1_grants",   32'(gq.size() - b_g), 1);
        check("t1_word",     32'(rx_at(b_rx)), 32'(w(0, 8'hA5)));
        check("t1_idle",     32'(busy), 0);

        // All four held valid: strict rotation from requester 0.
        do_reset("rst2");
        b_rx = rx_q.size();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) pend[i].push_back(8'(8'h10 + i));
        wait_rx(b_rx + 6, 600);
        begin
            int exp_id [6] = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6; k++)
                check($sformatf("t2_word%0d", k), 32'(rx_at(b_rx + k)),
                      32'(w(exp_id[k], 8'(8'h10 + exp_id[k]))));
        end

        // Stall: dst_ready low for 20 dst cycles with another requester waiting.
        do_reset("rst3");
        rdy_en = 1'b0;
        b_rx = rx_q.size();
        pend[1].push_back(8'h3C);
        for (int c = 0; c < 200 && !dst_valid; c++) @(negedge clk_dst);
        check("t3_valid_seen", 32'(dst_valid), 1);
        src_sync();
        pend[0].push_back(8'h0F);
        repeat (3) @(negedge clk_src);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_dst);
            check($sformatf("t3_stall%0d", c), 32'({dst_valid, dst_id, dst_data, busy, src_ready}),
                  32'({1'b1, 2'd1, 8'h3C, 1'b1, 4'b0000}));
        end
        rdy_en = 1'b1;
        wait_rx(b_rx + 2, 400);
        check("t3_first",  32'(rx_at(b_rx)),     32'(w(1, 8'h3C)));
        check("t3_second", 32'(rx_at(b_rx + 1)), 32'(w(0, 8'h0F)));

        // Reset while the source FSM sits in REQ.
        do_reset("rst4");
        pend[2].push_back(8'h77);
        for (int c = 0; c < 50 && !busy; c++) @(negedge clk_src);
        check("t4_in_req", 32'(busy), 1);
        #1;
        async_reset = 1'b0;
        #1;
        check("t4_rst_dst_valid", 32'(dst_valid), 0);
        check("t4_rst_busy",      32'(busy), 0);
        check("t4_rst_src_ready", 32'(src_ready), 0);
        release_reset();
        b_rx = rx_q.size();
        pend[0].push_back(8'h5A);
        pend[3].push_back(8'h33);
        wait_rx(b_rx + 2, 400);
        repeat (40) @(negedge clk_dst);
        check("t4_count",  32'(rx_q.size() - b_rx), 2);
        check("t4_first",  32'(rx_at(b_rx)),     32'(w(0, 8'h5A)));
        check("t4_second", 32'(rx_at(b_rx + 1)), 32'(w(3, 8'h33)));

        // Requester 2 granted, then 1 and 3 arrive while busy: 3 before 1.
        do_reset("rst5");
        b_rx = rx_q.size();
        b_g  = gq.size();
        pend[2].push_back(8'h22);
        for (int c = 0; c < 50 && gq.size() == b_g; c++) @(negedge clk_src);
        check("t5_busy_after_grant", 32'(busy), 1);
        src_sync();
        pend[1].push_back(8'h11);
        pend[3].push_back(8'h33);
        wait_rx(b_rx + 3, 600);
        check("t5_grant0", 32'(gq_at(b_g)),     32'(w(2, 8'h22)));
        check("t5_grant1", 32'(gq_at(b_g + 1)), 32'(w(3, 8'h33)));
        check("t5_grant2", 32'(gq_at(b_g + 2)), 32'(w(1, 8'h11)));
        check("t5_rx0",    32'(rx_at(b_rx)),     32'(w(2, 8'h22)));
        check("t5_rx1",    32'(rx_at(b_rx + 1)), 32'(w(3, 8'h33)));
        check("t5_rx2",    32'(rx_at(b_rx + 2)), 32'(w(1, 8'h11)));

        // Random traffic, fast source / slow destination, then reversed.
        src_half = 5.0;
        dst_half = 13.5;
        run_random("t6a", 500);
        src_half = 13.5;
        dst_half = 5.0;
        run_random("t6b", 500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
